md_sequencer: RTL and testbench
===============================

Name: md_sequencer

Overview:
- Multiply/divide unit sequencer for the 5-stage MIPS pipeline, sitting in the E stage beside the ALU.
- Accepts mult/multu/div/divu/mthi/mtlo from the E-stage instruction.
- Produces the start and busy signals the hazard unit uses to stall mt/mf instructions in D.
- Owns the HI/LO registers and models fixed multi-cycle latency with a countdown.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
clk  input  1  clock; all registers update on the rising edge
reset  input  1  asynchronous, active-low reset
md_valid  input  1  E-stage instruction is a valid md-class op (0 during bubble/flush)
md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
rs_data  input  32  forwarded E-stage rs operand
rt_data  input  32  forwarded E-stage rt operand
rd_sel  input  1  mf read select: 0 LO, 1 HI
start  output  1  combinational; 1 when a mult/div is accepted this cycle
busy  output  1  registered; 1 while an operation is in flight
hi  output  32  HI register
lo  output  32  LO register
md_rdata  output  32  combinational: rd_sel ? hi : lo

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - state to IDLE
  - count=0, busy=0
  - hi=lo=0
  - pending result registers to 0
- start is 0 during reset.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, count holds the remaining cycles.
- Accept condition: start = md_valid && md_op in {1..4} && state==IDLE.
- IDLE, on start:
  - Compute the result from rs_data/rt_data and latch it into pend_hi/pend_lo.
  - Load count with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
  - hi/lo are unchanged on this edge.
- RUN:
  - On each edge, count decrements.
  - On the edge where count==1: hi<=pend_hi, lo<=pend_lo, busy falls, state returns to IDLE.
  - Hence busy is high for exactly N cycles after the accept cycle, and new hi/lo are visible in the cycle busy first reads 0.
- mthi/mtlo, md_op 5/6 with md_valid and state==IDLE:
  - On the next edge, hi<=rs_data (op 5) or lo<=rs_data (op 6).
  - start stays 0; busy stays 0.
- Any md op arriving while state==RUN is ignored: start=0, no write, count undisturbed.
  - The hazard unit guarantees this never happens legally; the bench checks that it is ignored.
- Arithmetic rules:
  - mult: signed 32x32 to 64-bit product; {pend_hi,pend_lo} = product.
  - multu: unsigned 32x32 to 64-bit product.
  - div (signed): pend_lo = quotient truncated toward zero; pend_hi = remainder with the sign of the dividend.
  - divu (unsigned): pend_lo = quotient, pend_hi = remainder.
- Divide by zero (div and divu): pend_lo = 32'hFFFFFFFF, pend_hi = rs_data. No exception is raised.
- Signed overflow (rs=32'h80000000, rt=32'hFFFFFFFF): pend_lo = 32'h80000000, pend_hi = 0.
- Simultaneous events:
  - Completion edge (count==1) with a new md op presented that same cycle: the op is ignored, because state is still RUN.
  - A back-to-back op is accepted one cycle after busy falls.
- Reset mid-operation: the in-flight result is discarded; hi/lo return to 0 immediately (asynchronously).
- md_rdata always reflects the committed hi/lo, never the pending values.
- md_rdata is combinational, so an mf in E sees the value written on the prior edge.

Test Plan:
- Reset check: reset=0 asynchronously mid-cycle -> busy=0, start=0, hi=lo=0 immediately.
- mult:
  - Stimulus: rs=32'hFFFFFFFE (-2), rt=3, md_op=1, one cycle.
  - start=1 that cycle, then busy=1 for 5 cycles.
  - After busy falls: hi=32'hFFFFFFFF, lo=32'hFFFFFFFA.
  - hi/lo unchanged during busy.
- multu with the same operands -> after 5 busy cycles: hi=32'h00000002, lo=32'hFFFFFFFA.
- div:
  - rs=-7 (32'hFFFFFFF9), rt=2 -> busy for 10 cycles, then lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1).
  - divu 7/0 -> lo=32'hFFFFFFFF, hi=7.
- Overflow and mt writes:
  - div 32'h80000000/32'hFFFFFFFF -> lo=32'h80000000, hi=0.
  - mthi rs=32'h12345678 while IDLE -> hi=32'h12345678 next edge, busy=0, start=0.
  - mtlo presented during RUN -> lo unchanged.
- Contention:
  - mult issued at the completion cycle of a prior div -> ignored (start=0).
  - Reissue one cycle later -> start=1.
  - Reset asserted on busy cycle 3 of a div -> hi/lo=0, busy=0, no later commit.

Source files
------------

// File: rtl/md_sequencer_if.sv
// Multiply/divide sequencer E-stage bundle: operands and op in, start/busy/HI/LO out.
interface md_sequencer_if;
  logic        md_valid;
  logic [2:0]  md_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        rd_sel;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_rdata;

  modport master (
    output md_valid, md_op, rs_data, rt_data, rd_sel,
    input  start, busy, hi, lo, md_rdata
  );

  modport slave (
    input  md_valid, md_op, rs_data, rt_data, rd_sel,
    output start, busy, hi, lo, md_rdata
  );
endinterface

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer: computes the result on accept, holds it pending,
// and commits it to HI/LO after a fixed countdown.
//
// state  | meaning
// S_IDLE | no op in flight; accepts mult/div and mthi/mtlo
// S_RUN  | op in flight; count = remaining busy cycles, all md ops ignored
module md_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset,
  md_sequencer_if.slave md
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state;
  logic [3:0]  count;
  logic        busy_q;
  logic [31:0] hi_q, lo_q, pend_hi, pend_lo;

  logic        is_muldiv, is_div, is_signed, neg_a, neg_b;
  logic [31:0] mag_a, mag_b, div_b, q_mag, r_mag;
  logic [63:0] prod;
  logic [31:0] res_hi, res_lo;

  // Signed divide goes through magnitudes so the overflow case falls out naturally.
  always_comb begin
    is_muldiv = (md.md_op >= 3'd1) && (md.md_op <= 3'd4);
    is_div    = (md.md_op == 3'd3) || (md.md_op == 3'd4);
    is_signed = (md.md_op == 3'd1) || (md.md_op == 3'd3);
    neg_a     = is_signed & md.rs_data[31];
    neg_b     = is_signed & md.rt_data[31];
    mag_a     = neg_a ? -md.rs_data : md.rs_data;
    mag_b     = neg_b ? -md.rt_data : md.rt_data;
    div_b     = (md.rt_data == 32'd0) ? 32'd1 : mag_b;
    q_mag     = mag_a / div_b;
    r_mag     = mag_a % div_b;
    prod      = is_signed ? ({{32{md.rs_data[31]}}, md.rs_data} * {{32{md.rt_data[31]}}, md.rt_data})
                          : ({32'd0, md.rs_data} * {32'd0, md.rt_data});
    res_hi    = prod[63:32];
    res_lo    = prod[31:0];
    if (is_div) begin
      if (md.rt_data == 32'd0) begin
        res_lo = 32'hFFFF_FFFF;
        res_hi = md.rs_data;
      end else begin
        res_lo = (neg_a ^ neg_b) ? -q_mag : q_mag;
        res_hi = neg_a ? -r_mag : r_mag;
      end
    end
  end

  assign md.start    = reset && md.md_valid && is_muldiv && (state == S_IDLE);
  assign md.busy     = busy_q;
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
  assign md.md_rdata = md.rd_sel ? hi_q : lo_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      count   <= 4'd0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (md.start) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            count   <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
            busy_q  <= 1'b1;
            state   <= S_RUN;
          end else if (md.md_valid && md.md_op == 3'd5) begin
            hi_q <= md.rs_data;
          end else if (md.md_valid && md.md_op == 3'd6) begin
            lo_q <= md.rs_data;
          end
        end
        S_RUN: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            hi_q   <= pend_hi;
            lo_q   <= pend_lo;
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: table of mult/div vectors plus
// hand-written sequences for mt writes, contention and reset mid-op.
module tb_md_sequencer;

  logic clk;
  logic reset;
  md_sequencer_if mdif ();

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mdif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  vec_t        vecs[10];

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic exp_start, input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    @(negedge clk);
    mdif.md_valid = 1'b1;
    mdif.md_op    = op;
    mdif.rs_data  = a;
    mdif.rt_data  = b;
    #1;
    check32("start", {31'd0, mdif.start}, {31'd0, exp_start});
    if (exp_start) begin
      e.hi = eh;
      e.lo = el;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    mdif.md_valid = 1'b0;
    mdif.md_op    = 3'd0;
  endtask

  task automatic commit_check(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s_scoreboard: got empty queue expected one entry", nm);
      return;
    end
    e    = sb.pop_front();
    m_hi = e.hi;
    m_lo = e.lo;
    check32({nm, "_hi"}, mdif.hi, m_hi);
    check32({nm, "_lo"}, mdif.lo, m_lo);
    mdif.rd_sel = 1'b1;
    #1;
    check32({nm, "_rdata_hi"}, mdif.md_rdata, m_hi);
    mdif.rd_sel = 1'b0;
    #1;
    check32({nm, "_rdata_lo"}, mdif.md_rdata, m_lo);
  endtask

  // Counts remaining busy cycles from now, checking HI/LO hold the model value meanwhile.
  task automatic wait_done(input string nm, input int exp_n);
    int n;
    int bad;
    n   = 0;
    bad = 0;
    while (mdif.busy && n < 40) begin
      if (mdif.hi !== m_hi || mdif.lo !== m_lo) bad++;
      n++;
      @(posedge clk);
      #1;
    end
    check32({nm, "_hold_bad_cycles"}, 32'(bad), 32'd0);
    check32({nm, "_busy_cycles"}, 32'(n), 32'(exp_n));
    commit_check(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1] = '{3'd2, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, 5};
    vecs[2] = '{3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3] = '{3'd4, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 10};
    vecs[4] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10};
    vecs[5] = '{3'd3, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 10};
    vecs[6] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         5};
    vecs[7] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         5};
    vecs[8] = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};
    vecs[9] = '{3'd4, 32'd100,       32'd7,         32'd2,         32'd14,        10};

    // Reset held with a mult presented: nothing may start.
    reset         = 1'b0;
    mdif.md_valid = 1'b1;
    mdif.md_op    = 3'd1;
    mdif.rs_data  = 32'd5;
    mdif.rt_data  = 32'd6;
    mdif.rd_sel   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check32("rst_start", {31'd0, mdif.start}, 32'd0);
    check32("rst_busy",  {31'd0, mdif.busy},  32'd0);
    check32("rst_hi", mdif.hi, 32'd0);
    check32("rst_lo", mdif.lo, 32'd0);
    mdif.md_valid = 1'b0;
    mdif.md_op    = 3'd0;
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt, 1'b1, vecs[i].hi, vecs[i].lo);
      wait_done($sformatf("vec%0d", i), vecs[i].cyc);
    end

    // mthi while idle
    @(negedge clk);
    mdif.md_valid = 1'b1;
    mdif.md_op    = 3'd5;
    mdif.rs_data  = 32'h1234_5678;
    #1;
    check32("mthi_start", {31'd0, mdif.start}, 32'd0);
    @(posedge clk);
    #1;
    mdif.md_valid = 1'b0;
    mdif.md_op    = 3'd0;
    m_hi = 32'h1234_5678;
    check32("mthi_hi",   mdif.hi, m_hi);
    check32("mthi_lo",   mdif.lo, m_lo);
    check32("mthi_busy", {31'd0, mdif.busy}, 32'd0);

    // mtlo during RUN is ignored
    issue(3'd1, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42);
    @(negedge clk);
    mdif.md_valid = 1'b1;
    mdif.md_op    = 3'd6;
    mdif.rs_data  = 32'hDEAD_BEEF;
    #1;
    check32("mtlo_run_start", {31'd0, mdif.start}, 32'd0);
    @(posedge clk);
    #1;
    mdif.md_valid = 1'b0;
    mdif.md_op    = 3'd0;
    check32("mtlo_run_lo", mdif.lo, m_lo);
    wait_done("mtlo_run", 4);

    // mult presented on the div completion cycle is dropped, reissue next cycle accepted
    issue(3'd4, 32'd50, 32'd8, 1'b1, 32'd2, 32'd6);
    repeat (9) @(posedge clk);
    #1;
    check32("cont_busy_last", {31'd0, mdif.busy}, 32'd1);
    issue(3'd1, 32'd3, 32'd3, 1'b0, 32'd0, 32'd0);
    check32("cont_busy_fell", {31'd0, mdif.busy}, 32'd0);
    commit_check("cont_div");
    issue(3'd1, 32'd3, 32'd3, 1'b1, 32'd0, 32'd9);
    wait_done("cont_reissue", 5);

    // Async reset on busy cycle 3 of a div discards the result
    issue(3'd3, 32'd100, 32'd3, 1'b1, 32'd1, 32'd33);
    repeat (2) @(posedge clk);
    #2;
    mdif.md_valid = 1'b1;
    mdif.md_op    = 3'd1;
    reset = 1'b0;
    #1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    void'(sb.pop_front());
    check32("rst_mid_hi",    mdif.hi, 32'd0);
    check32("rst_mid_lo",    mdif.lo, 32'd0);
    check32("rst_mid_busy",  {31'd0, mdif.busy},  32'd0);
    check32("rst_mid_start", {31'd0, mdif.start}, 32'd0);
    mdif.md_valid = 1'b0;
    mdif.md_op    = 3'd0;
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check32("rst_after_hi",   mdif.hi, 32'd0);
    check32("rst_after_lo",   mdif.lo, 32'd0);
    check32("rst_after_busy", {31'd0, mdif.busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
